// File: rtl/uart_prog_loader_pkg.sv
// Shared types and constants for the UART program loader: loader/receiver state
// encodings, default bit timing and the instruction word width.
package uart_prog_loader_pkg;

    localparam int REGWIDTH         = 32;
    localparam int LDR_CLKS_PER_BIT = 868;

    typedef enum logic [2:0] {
        LDR_IDLE   = 3'd0,
        LDR_LEN_LO = 3'd1,
        LDR_LEN_HI = 3'd2,
        LDR_WORD   = 3'd3,
        LDR_WRITE  = 3'd4
    } ldr_state_t;

    typedef enum logic [1:0] {
        RX_IDLE  = 2'd0,
        RX_START = 2'd1,
        RX_DATA  = 2'd2,
        RX_STOP  = 2'd3
    } rx_state_t;

endpackage

// File: rtl/uart_prog_loader_rx_byte.sv
// 8N1 UART byte receiver: 2-FF synchroniser, mid-bit sampling, glitch rejection
// on the start bit and stop-bit framing check.
module uart_rx_byte
    import uart_prog_loader_pkg::*;
#(
    parameter int CLKS_PER_BIT = LDR_CLKS_PER_BIT
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    output logic       byte_valid,
    output logic [7:0] byte_data,
    output logic       frame_err
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] FULL = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] HALF = CW'(CLKS_PER_BIT / 2 - 1);

    rx_state_t     state_reg;
    logic          rx_meta_reg, rx_sync_reg, rx_prev_reg;
    logic [CW-1:0] cnt_reg;
    logic [2:0]    bit_idx_reg;
    logic [7:0]    shift_reg;
    logic          byte_valid_reg, frame_err_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg      <= RX_IDLE;
            rx_meta_reg    <= 1'b1;
            rx_sync_reg    <= 1'b1;
            rx_prev_reg    <= 1'b1;
            cnt_reg        <= '0;
            bit_idx_reg    <= '0;
            shift_reg      <= '0;
            byte_valid_reg <= 1'b0;
            frame_err_reg  <= 1'b0;
        end else begin
            rx_meta_reg    <= rx;
            rx_sync_reg    <= rx_meta_reg;
            rx_prev_reg    <= rx_sync_reg;
            byte_valid_reg <= 1'b0;
            frame_err_reg  <= 1'b0;
            case (state_reg)
                // Only a true high-to-low transition starts a frame, so a line
                // held low after a framing error does not retrigger.
                RX_IDLE: begin
                    if (rx_prev_reg && !rx_sync_reg) begin
                        state_reg <= RX_START;
                        cnt_reg   <= '0;
                    end
                end
                RX_START: begin
                    if (cnt_reg == HALF) begin
                        cnt_reg     <= '0;
                        bit_idx_reg <= '0;
                        state_reg   <= rx_sync_reg ? RX_IDLE : RX_DATA;
                    end else begin
                        cnt_reg <= cnt_reg + CW'(1);
                    end
                end
                RX_DATA: begin
                    if (cnt_reg == FULL) begin
                        cnt_reg     <= '0;
                        shift_reg   <= {rx_sync_reg, shift_reg[7:1]};
                        bit_idx_reg <= bit_idx_reg + 3'd1;
                        if (bit_idx_reg == 3'd7)
                            state_reg <= RX_STOP;
                    end else begin
                        cnt_reg <= cnt_reg + CW'(1);
                    end
                end
                RX_STOP: begin
                    if (cnt_reg == FULL) begin
                        cnt_reg        <= '0;
                        byte_valid_reg <= rx_sync_reg;
                        frame_err_reg  <= !rx_sync_reg;
                        state_reg      <= RX_IDLE;
                    end else begin
                        cnt_reg <= cnt_reg + CW'(1);
                    end
                end
                default: state_reg <= RX_IDLE;
            endcase
        end
    end

    assign byte_valid = byte_valid_reg;
    assign byte_data  = shift_reg;
    assign frame_err  = frame_err_reg;

endmodule

// File: rtl/uart_prog_loader.sv
// Loads a length-prefixed little-endian program image from UART into
// instruction memory; busy holds the CPU in reset while loading.
module uart_prog_loader
    import uart_prog_loader_pkg::*;
#(
    parameter int CLKS_PER_BIT = LDR_CLKS_PER_BIT,
    parameter int ADDR_WIDTH   = 14
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  rx,
    output logic                  busy,
    output logic                  done,
    output logic                  err,
    output logic                  imem_we,
    output logic [ADDR_WIDTH-1:0] imem_addr,
    output logic [REGWIDTH-1:0]   imem_wdata,
    output logic [ADDR_WIDTH:0]   word_count
);

    localparam logic [16:0]       MAX_WORDS = 17'(1) << ADDR_WIDTH;
    localparam logic [ADDR_WIDTH:0] WC_ONE  = (ADDR_WIDTH+1)'(1);

    logic       byte_valid, frame_err;
    logic [7:0] byte_data;

    uart_rx_byte #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx (
        .clk        (clk),
        .rst        (rst),
        .rx         (rx),
        .byte_valid (byte_valid),
        .byte_data  (byte_data),
        .frame_err  (frame_err)
    );

    ldr_state_t            state_reg;
    logic [15:0]           len_reg;
    logic [1:0]            byte_idx_reg;
    logic [23:0]           word_reg;
    logic [ADDR_WIDTH:0]   word_count_reg;
    logic                  done_reg, err_reg, imem_we_reg;
    logic [ADDR_WIDTH-1:0] imem_addr_reg;
    logic [REGWIDTH-1:0]   imem_wdata_reg;

    logic [15:0]         len_full;
    logic [ADDR_WIDTH:0] wc_plus;
    assign len_full = {byte_data, len_reg[7:0]};
    assign wc_plus  = word_count_reg + WC_ONE;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg      <= LDR_IDLE;
            len_reg        <= '0;
            byte_idx_reg   <= '0;
            word_reg       <= '0;
            word_count_reg <= '0;
            done_reg       <= 1'b0;
            err_reg        <= 1'b0;
            imem_we_reg    <= 1'b0;
            imem_addr_reg  <= '0;
            imem_wdata_reg <= '0;
        end else begin
            imem_we_reg <= 1'b0;
            if (state_reg != LDR_IDLE && frame_err) begin
                err_reg   <= 1'b1;
                state_reg <= LDR_IDLE;
            end else begin
                case (state_reg)
                    LDR_IDLE: begin
                        if (start) begin
                            done_reg       <= 1'b0;
                            err_reg        <= 1'b0;
                            word_count_reg <= '0;
                            state_reg      <= LDR_LEN_LO;
                        end
                    end
                    LDR_LEN_LO: begin
                        if (byte_valid) begin
                            len_reg[7:0] <= byte_data;
                            state_reg    <= LDR_LEN_HI;
                        end
                    end
                    LDR_LEN_HI: begin
                        if (byte_valid) begin
                            len_reg      <= len_full;
                            byte_idx_reg <= '0;
                            if ({1'b0, len_full} > MAX_WORDS) begin
                                err_reg   <= 1'b1;
                                state_reg <= LDR_IDLE;
                            end else if (len_full == 16'd0) begin
                                done_reg  <= 1'b1;
                                state_reg <= LDR_IDLE;
                            end else begin
                                state_reg <= LDR_WORD;
                            end
                        end
                    end
                    // The strobe is launched on the 4th byte so it lands in the
                    // WRITE cycle, one cycle after that byte's byte_valid.
                    LDR_WORD: begin
                        if (byte_valid) begin
                            word_reg     <= {byte_data, word_reg[23:8]};
                            byte_idx_reg <= byte_idx_reg + 2'd1;
                            if (byte_idx_reg == 2'd3) begin
                                imem_we_reg    <= 1'b1;
                                imem_addr_reg  <= word_count_reg[ADDR_WIDTH-1:0];
                                imem_wdata_reg <= {byte_data, word_reg};
                                state_reg      <= LDR_WRITE;
                            end
                        end
                    end
                    LDR_WRITE: begin
                        word_count_reg <= wc_plus;
                        if (17'(wc_plus) == {1'b0, len_reg}) begin
                            done_reg  <= 1'b1;
                            state_reg <= LDR_IDLE;
                        end else begin
                            state_reg <= LDR_WORD;
                        end
                    end
                    default: state_reg <= LDR_IDLE;
                endcase
            end
        end
    end

    assign busy       = (state_reg != LDR_IDLE);
    assign done       = done_reg;
    assign err        = err_reg;
    assign imem_we    = imem_we_reg;
    assign imem_addr  = imem_addr_reg;
    assign imem_wdata = imem_wdata_reg;
    assign word_count = word_count_reg;

endmodule

// File: tb/tb_uart_prog_loader.sv
// Randomized scoreboard bench for uart_prog_loader: expected memory writes are
// queued from a byte-level image model and matched by an independent monitor.
module tb_uart_prog_loader;

    localparam int CPB = 16;
    localparam int AW  = 4;
    localparam int DEPTH = 1 << AW;

    logic          clk = 1'b0;
    logic          rst, start, rx;
    logic          busy, done, err, imem_we;
    logic [AW-1:0] imem_addr;
    logic [31:0]   imem_wdata;
    logic [AW:0]   word_count;

    uart_prog_loader #(.CLKS_PER_BIT(CPB), .ADDR_WIDTH(AW)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .rx         (rx),
        .busy       (busy),
        .done       (done),
        .err        (err),
        .imem_we    (imem_we),
        .imem_addr  (imem_addr),
        .imem_wdata (imem_wdata),
        .word_count (word_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [AW-1:0] addr;
        logic [31:0]   data;
    } wr_t;

    wr_t exp_q[$];
    int  check_cnt = 0;
    int  pass_cnt  = 0;

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        check_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // Monitor: every write strobe must match the oldest queued expectation.
    always @(negedge clk) begin
        if (!rst && imem_we) begin
            if (exp_q.size() == 0) begin
                check_cnt++;
                $display("FAIL unexpected_write: got addr=%h data=%h expected no write", imem_addr, imem_wdata);
            end else begin
                wr_t e;
                e = exp_q.pop_front();
                $display("write addr=%h data=%h (expected %h %h)", imem_addr, imem_wdata, e.addr, e.data);
                check("write_addr", 32'(imem_addr), 32'(e.addr));
                check("write_data", imem_wdata, e.data);
            end
        end
    end

    task automatic send_bit(logic b);
        rx = b;
        repeat (CPB) @(negedge clk);
    endtask

    task automatic send_byte(logic [7:0] b, logic stop_bit = 1'b1);
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(b[i]);
        send_bit(stop_bit);
        if (!stop_bit) send_bit(1'b1);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_idle(string name);
        int n;
        n = 0;
        while (busy && n < 200) begin
            @(negedge clk);
            n++;
        end
        check({name, "_idle_timeout"}, 32'(busy), 32'd0);
    endtask

    task automatic check_status(string name, logic d, logic e, int wc);
        check({name, "_done"}, 32'(done), 32'(d));
        check({name, "_err"}, 32'(err), 32'(e));
        check({name, "_busy"}, 32'(busy), 32'd0);
        check({name, "_wc"}, 32'(word_count), 32'(wc));
        check({name, "_pending"}, 32'(exp_q.size()), 32'd0);
    endtask

    // Reference: image = LEN (LE 16-bit) then N little-endian words; N beyond
    // the memory depth is rejected right after the length bytes.
    task automatic run_load(string name, int n);
        logic [31:0] w;
        logic        ovr;
        ovr = (n > DEPTH);
        pulse_start();
        send_byte(8'(n));
        send_byte(8'(n >> 8));
        if (!ovr) begin
            for (int i = 0; i < n; i++) begin
                w = $urandom;
                exp_q.push_back('{addr: AW'(i), data: w});
                for (int k = 0; k < 4; k++) send_byte(8'(w >> (8 * k)));
            end
        end
        wait_idle(name);
        $display("load %s n=%0d done=%0b err=%0b wc=%0d", name, n, done, err, word_count);
        check_status(name, !ovr, ovr, ovr ? 0 : n);
    endtask

    initial begin
        logic [31:0] w;
        rst = 1'b1; start = 1'b0; rx = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_err", 32'(err), 32'd0);
        check("rst_we", 32'(imem_we), 32'd0);
        check("rst_wc", 32'(word_count), 32'd0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // Basic fixed image.
        pulse_start();
        exp_q.push_back('{addr: 4'd0, data: 32'h00A00513});
        exp_q.push_back('{addr: 4'd1, data: 32'h00B00593});
        begin
            logic [7:0] img [10] = '{8'h02, 8'h00, 8'h13, 8'h05, 8'hA0, 8'h00,
                                     8'h93, 8'h05, 8'hB0, 8'h00};
            for (int i = 0; i < 10; i++) send_byte(img[i]);
        end
        wait_idle("basic");
        check_status("basic", 1'b1, 1'b0, 2);

        run_load("zero", 0);
        for (int t = 0; t < 3; t++) run_load("rand", int'($urandom_range(1, 5)));
        run_load("full", DEPTH);
        run_load("oversize", DEPTH + 1);

        // Framing error on the 3rd data byte.
        pulse_start();
        send_byte(8'h01); send_byte(8'h00);
        send_byte(8'h11); send_byte(8'h22);
        send_byte(8'h33, 1'b0);
        wait_idle("framing");
        check_status("framing", 1'b0, 1'b1, 0);

        // Glitch and start-while-busy during a load.
        pulse_start();
        send_byte(8'h03); send_byte(8'h00);
        rx = 1'b0;
        repeat (3) @(negedge clk);
        rx = 1'b1;
        repeat (2 * CPB) @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            w = $urandom;
            exp_q.push_back('{addr: AW'(i), data: w});
            for (int k = 0; k < 4; k++) send_byte(8'(w >> (8 * k)));
            if (i == 0) begin
                pulse_start();
                check("ignore_start_wc", 32'(word_count), 32'd1);
                check("ignore_start_busy", 32'(busy), 32'd1);
            end
        end
        wait_idle("glitch");
        check_status("glitch", 1'b1, 1'b0, 3);

        // Reset after 5 data bytes, then a clean reload from address 0.
        pulse_start();
        send_byte(8'h02); send_byte(8'h00);
        w = $urandom;
        exp_q.push_back('{addr: 4'd0, data: w});
        for (int k = 0; k < 4; k++) send_byte(8'(w >> (8 * k)));
        send_byte(8'h5A);
        rst = 1'b1;
        @(negedge clk);
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_done", 32'(done), 32'd0);
        check("midrst_err", 32'(err), 32'd0);
        check("midrst_wc", 32'(word_count), 32'd0);
        check("midrst_addr", 32'(imem_addr), 32'd0);
        check("midrst_wdata", imem_wdata, 32'd0);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        run_load("reload", 2);

        repeat (5) @(negedge clk);
        $display("%0d/%0d checks passed", pass_cnt, check_cnt);
        $finish;
    end

endmodule

// File: doc/uart_prog_loader.md
# uart_prog_loader

Serial program loader that sits directly upstream of `instruction_fetch`. On a `start` pulse it receives a length-prefixed program image over a UART RX line, assembles little-endian 32-bit words and writes them sequentially into instruction memory. `busy` is ORed into the CPU reset (`cpu_rst = rst | busy`) so `PC` and the core stay at reset while memory is being rewritten. Programs can be reloaded on the board without re-synthesising the COE image.

## Interface
- `CLKS_PER_BIT`, 868, clock cycles per UART bit (100 MHz / 115200); legal range ≥ 4.
- `ADDR_WIDTH`, 14, instruction-memory word-address width; depth = 2^ADDR_WIDTH words.
- `clk  in  1  system clock; single clock domain.`
- `rst  in  1  asynchronous, active-high reset.`
- `start  in  1  one-cycle pulse; begins a load. Ignored while busy.`
- `rx  in  1  UART RX line, idle high, asynchronous to clk.`
- `busy  out  1  high from accepted start until load completes or aborts.`
- `done  out  1  sticky; set on successful completion, cleared by next accepted start or rst.`
- `err  out  1  sticky; set on framing error or oversize length, cleared by next accepted start or rst.`
- `imem_we  out  1  one-cycle write strobe to instruction memory.`
- `imem_addr  out  ADDR_WIDTH  word address of the current write.`
- `imem_wdata  out  `REGWIDTH`  assembled instruction word.`
- `word_count  out  ADDR_WIDTH+1  number of words written in this load.`

## Operation
- Frame format: 8N1, LSB first. Image = LEN_LO, LEN_HI (16-bit word count N), then 4·N bytes, each word little-endian (first byte → bits 7:0).
- RX path: `rx` passes through a 2-FF synchroniser. Byte receiver: idle until a falling edge, waits CLKS_PER_BIT/2 and re-samples. If high, the edge was a glitch: return to idle with no byte. Otherwise sample 8 data bits and the stop bit at CLKS_PER_BIT intervals. Stop=1 → `byte_valid` pulse with data. Stop=0 → `frame_err` pulse.
- Loader FSM states: IDLE, LEN_LO, LEN_HI, WORD, WRITE.
  - IDLE: on `start`, clear `done`, `err` and `word_count`; set `busy`; go to LEN_LO.
  - LEN_LO / LEN_HI: latch each byte.
    - After LEN_HI, if N > 2^ADDR_WIDTH, set `err` and go to IDLE.
    - If N = 0, set `done` and go to IDLE.
    - Otherwise go to WORD with byte_idx = 0.
  - WORD: shift bytes into the word register. On the 4th byte go to WRITE.
  - WRITE: one cycle. Pulse `imem_we`, `imem_addr` = word_count[ADDR_WIDTH-1:0], increment `word_count`. If word_count+1 = N, set `done` and go to IDLE; else go to WORD.
- `frame_err` in any non-IDLE state: set `err` and go to IDLE. Memory already written is not rolled back.
- Bytes arriving in IDLE are discarded. `start` while busy is ignored.
- `busy` = (state ≠ IDLE).

## Timing
- Reset values: every output is 0, state IDLE, all counters 0. Reset mid-load aborts immediately. Instruction memory contents are untouched.
- `byte_valid` asserts in the cycle after the stop-bit sample. The synchroniser adds 2 cycles of input latency.
- `imem_we` asserts exactly 1 cycle after the 4th byte's `byte_valid`. `imem_addr` and `imem_wdata` are stable in that cycle.
- On the last write, `done` rises and `busy` falls in the cycle after the `imem_we` pulse. The CPU leaves reset on that edge with PC = 0.
- Bytes are accepted back-to-back with no idle gap; throughput is one word per 40·CLKS_PER_BIT cycles.
- `start` coinciding with `rst`: rst wins.

## Structure
- Sub-module `uart_rx_byte`: synchroniser, bit-timing counter, start/stop checks; outputs `byte_valid`, `byte_data[7:0]`, `frame_err`.
- Loader FSM state encodings (`LDR_IDLE`…`LDR_WRITE`, 3 bits) and the default `LDR_CLKS_PER_BIT` go in the shared `variables.vh`. Word width uses the existing `REGWIDTH`.

## Test plan
- Basic load (CLKS_PER_BIT=16): start; send 02 00 13 05 A0 00 93 05 B0 00 → writes 0x00A00513 @0 and 0x00B00593 @1. Then done=1, busy=0, err=0, word_count=2.
- Zero length: send 00 00 → done=1 within 1 cycle of LEN_HI, no imem_we.
- Framing error: stop bit forced 0 on the 3rd data byte → err=1, busy=0, done=0, no imem_we.
- Oversize (ADDR_WIDTH=4): send LEN=0x0011 → err=1, no writes.
- Glitch and ignore: a 3-cycle low pulse on rx produces no byte. A start pulse during a load leaves the counters unchanged.
- Reset mid-load: assert rst after 5 data bytes → all outputs 0. A new start followed by a full image loads correctly from address 0.
